thread_scheduler: RTL and testbench

//  Fetch-side thread scheduler for the barrel pipeline. Holds one PC per hardware thread and picks one

---
 rtl/thread_scheduler.sv | 128 ++++++++++++
 tb/tb_thread_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// Barrel-pipeline fetch scheduler: one PC per hardware thread,
// round-robin issue of active threads with redirect/start/halt control.
module thread_scheduler #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned NUM_THREADS   = 8,
  parameter int unsigned BITS_THREADS  = $clog2(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f,
  input  logic                     thread_start,
  input  logic [BITS_THREADS-1:0]  start_tid,
  input  logic [ADDRESS_WIDTH-1:0] start_pc,
  input  logic                     thread_halt,
  input  logic [BITS_THREADS-1:0]  halt_tid,
  input  logic                     redirect_e,
  input  logic [BITS_THREADS-1:0]  redirect_tid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_f,
  output logic [NUM_THREADS-1:0]   active_mask,
  output logic                     idle
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned NT = NUM_THREADS;
  localparam int unsigned BT = BITS_THREADS;

  logic [AW-1:0] pc_q [NT];
  logic [AW-1:0] pc_d [NT];
  logic [NT-1:0] active_q, active_d;
  logic [BT-1:0] last_q, last_d;
  logic [AW-1:0] pc_f_q, pc_f_d;
  logic [BT-1:0] tid_f_q, tid_f_d;
  logic          valid_q, valid_d;

  logic [NT-1:0] halt_oh;
  logic [NT-1:0] elig;
  logic [BT-1:0] sel;
  logic [BT-1:0] idx;
  logic          found;
  logic          issue;
  logic          byp;
  logic [AW-1:0] issue_pc;

  assign halt_oh = thread_halt ? (NT'(1) << halt_tid) : '0;
  assign elig    = active_q & ~halt_oh;

  // Scan last+1 .. last+NT; the final candidate is last itself.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(NT); k++) begin
      idx = last_q + BT'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign issue    = !stall_f && found;
  assign byp      = redirect_e && (redirect_tid == sel);
  assign issue_pc = byp ? redirect_pc : pc_q[sel];

  always_comb begin
    active_d = active_q;
    if (thread_start) active_d[start_tid] = 1'b1;
    if (thread_halt)  active_d[halt_tid]  = 1'b0;
  end

  // Redirect beats start beats increment; a bypassed redirect continues at target+4.
  always_comb begin
    for (int t = 0; t < int'(NT); t++) begin
      pc_d[t] = pc_q[t];
      if (redirect_e && redirect_tid == BT'(t)) begin
        pc_d[t] = (issue && sel == BT'(t)) ? redirect_pc + AW'(4) : redirect_pc;
      end else if (thread_start && start_tid == BT'(t)) begin
        pc_d[t] = start_pc;
      end else if (issue && sel == BT'(t)) begin
        pc_d[t] = issue_pc + AW'(4);
      end
    end
  end

  always_comb begin
    pc_f_d  = pc_f_q;
    tid_f_d = tid_f_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (!stall_f) begin
      valid_d = found;
      if (found) begin
        pc_f_d  = issue_pc;
        tid_f_d = sel;
        last_d  = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= NT'(1);
      last_q   <= BT'(NT - 1);
      pc_f_q   <= '0;
      tid_f_q  <= '0;
      valid_q  <= 1'b0;
      for (int t = 0; t < int'(NT); t++) pc_q[t] <= RESET_PC;
    end else begin
      active_q <= active_d;
      last_q   <= last_d;
      pc_f_q   <= pc_f_d;
      tid_f_q  <= tid_f_d;
      valid_q  <= valid_d;
      for (int t = 0; t < int'(NT); t++) pc_q[t] <= pc_d[t];
    end
  end

  assign pc_f        = pc_f_q;
  assign tid_f       = tid_f_q;
  assign valid_f     = valid_q;
  assign active_mask = active_q;
  assign idle        = (active_q == '0);

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: directed vector table, then random
// traffic against a behavioural model, then async reset checks.
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        thread_start;
  logic [2:0]  start_tid;
  logic [31:0] start_pc;
  logic        thread_halt;
  logic [2:0]  halt_tid;
  logic        redirect_e;
  logic [2:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_f;
  logic [2:0]  tid_f;
  logic        valid_f;
  logic [7:0]  active_mask;
  logic        idle;

  int checks = 0;
  int errors = 0;

  thread_scheduler dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f),
    .thread_start(thread_start), .start_tid(start_tid), .start_pc(start_pc),
    .thread_halt(thread_halt), .halt_tid(halt_tid),
    .redirect_e(redirect_e), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .pc_f(pc_f), .tid_f(tid_f), .valid_f(valid_f),
    .active_mask(active_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        st;
    logic [2:0]  stid;
    logic [31:0] spc;
    logic        ht;
    logic [2:0]  htid;
    logic        rd;
    logic [2:0]  rtid;
    logic [31:0] rpc;
    logic        e_valid;
    logic [2:0]  e_tid;
    logic [31:0] e_pc;
    logic [7:0]  e_mask;
  } vec_t;

  // Behavioural model state
  logic [31:0] m_pc [8];
  bit          m_act [8];
  int          m_last;
  logic [31:0] m_pcf;
  int          m_tid;
  bit          m_valid;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    stall_f = 0; thread_start = 0; start_tid = 0; start_pc = 0;
    thread_halt = 0; halt_tid = 0; redirect_e = 0; redirect_tid = 0;
    redirect_pc = 0;
  endtask

  task automatic model_reset();
    for (int t = 0; t < 8; t++) begin
      m_pc[t] = 0;
      m_act[t] = (t == 0);
    end
    m_last = 7; m_pcf = 0; m_tid = 0; m_valid = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_f), 0);
    chk("rst_tid", 32'(tid_f), 0);
    chk("rst_pc", pc_f, 0);
    chk("rst_mask", 32'(active_mask), 1);
    chk("rst_idle", 32'(idle), 0);
    rst_n = 1;
  endtask

  // Advance model by one edge using the currently driven inputs.
  task automatic model_step();
    bit elig [8];
    int sel;
    bit any;
    logic [31:0] ipc;
    sel = -1;
    for (int t = 0; t < 8; t++)
      elig[t] = m_act[t] && !(thread_halt && halt_tid == 3'(t));
    for (int k = 1; k <= 8; k++)
      if (sel < 0 && elig[(m_last + k) % 8]) sel = (m_last + k) % 8;
    any = (sel >= 0);
    ipc = 0;
    if (!stall_f) begin
      m_valid = any;
      if (any) begin
        ipc = (redirect_e && redirect_tid == 3'(sel)) ? redirect_pc : m_pc[sel];
        m_pcf = ipc; m_tid = sel; m_last = sel;
      end
    end
    if (!stall_f && any) m_pc[sel] = ipc + 32'd4;
    if (thread_start && !(redirect_e && redirect_tid == start_tid))
      m_pc[start_tid] = start_pc;
    if (redirect_e && !(!stall_f && any && redirect_tid == 3'(sel)))
      m_pc[redirect_tid] = redirect_pc;
    if (thread_start) m_act[start_tid] = 1;
    if (thread_halt) m_act[halt_tid] = 0;
  endtask

  task automatic step_chk(string tag);
    logic [7:0] em;
    model_step();
    @(posedge clk);
    #1;
    em = 0;
    for (int t = 0; t < 8; t++) em[t] = m_act[t];
    chk({tag, "_valid"}, 32'(valid_f), 32'(m_valid));
    chk({tag, "_tid"}, 32'(tid_f), 32'(m_tid));
    chk({tag, "_pc"}, pc_f, m_pcf);
    chk({tag, "_mask"}, 32'(active_mask), 32'(em));
    chk({tag, "_idle"}, 32'(idle), 32'(em == 0));
  endtask

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{0,0,0,0,          0,0,0,0,0,     1,0,32'h0,         8'h01};
    tbl[1]  = '{0,0,0,0,          0,0,0,0,0,     1,0,32'h4,         8'h01};
    tbl[2]  = '{0,1,1,32'h100,    0,0,0,0,0,     1,0,32'h8,         8'h03};
    tbl[3]  = '{0,0,0,0,          0,0,0,0,0,     1,1,32'h100,       8'h03};
    tbl[4]  = '{1,0,0,0,          0,0,0,0,0,     1,1,32'h100,       8'h03};
    tbl[5]  = '{0,0,0,0,          0,0,1,0,32'h40,1,0,32'h40,        8'h03};
    tbl[6]  = '{0,0,0,0,          1,1,0,0,0,     1,0,32'h44,        8'h01};
    tbl[7]  = '{0,0,0,0,          1,0,0,0,0,     0,0,32'h44,        8'h00};
    tbl[8]  = '{0,1,2,32'hFFFFFFFC,0,0,0,0,0,    0,0,32'h44,        8'h04};
    tbl[9]  = '{0,0,0,0,          0,0,0,0,0,     1,2,32'hFFFFFFFC,  8'h04};
    tbl[10] = '{0,0,0,0,          0,0,0,0,0,     1,2,32'h0,         8'h04};
    tbl[11] = '{0,1,5,32'h500,    1,5,0,0,0,     1,2,32'h4,         8'h04};
    tbl[12] = '{0,0,0,0,          0,0,1,5,32'h600,1,2,32'h8,        8'h04};
    tbl[13] = '{0,1,5,32'h700,    0,0,0,0,0,     1,2,32'hC,         8'h24};
    tbl[14] = '{0,0,0,0,          0,0,0,0,0,     1,5,32'h700,       8'h24};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      stall_f = tbl[i].stall;
      thread_start = tbl[i].st; start_tid = tbl[i].stid; start_pc = tbl[i].spc;
      thread_halt = tbl[i].ht; halt_tid = tbl[i].htid;
      redirect_e = tbl[i].rd; redirect_tid = tbl[i].rtid; redirect_pc = tbl[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(valid_f), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_tid", i), 32'(tid_f), 32'(tbl[i].e_tid));
      chk($sformatf("v%0d_pc", i), pc_f, tbl[i].e_pc);
      chk($sformatf("v%0d_mask", i), 32'(active_mask), 32'(tbl[i].e_mask));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tbl[i].e_mask == 0));
    end

    // Start tids 1..7 then round-robin with stall and bypassed redirect
    do_reset();
    for (int t = 1; t < 8; t++) begin
      clr_in();
      thread_start = 1; start_tid = 3'(t); start_pc = 32'(t) * 32'h100;
      step_chk("start");
    end
    clr_in();
    for (int i = 0; i < 10; i++) step_chk("rr");
    redirect_e = 1; redirect_tid = 3'((m_last + 1) % 8); redirect_pc = 32'h200;
    step_chk("byp");
    clr_in();
    stall_f = 1;
    for (int i = 0; i < 3; i++) step_chk("stall");
    clr_in();
    for (int i = 0; i < 9; i++) step_chk("rr2");
    thread_start = 1; thread_halt = 1; start_tid = 6; halt_tid = 6;
    start_pc = 32'h666;
    step_chk("sthalt");

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      clr_in();
      stall_f      = ($urandom_range(7) == 0);
      thread_start = ($urandom_range(3) == 0);
      start_tid    = 3'($urandom_range(7));
      start_pc     = ($urandom_range(7) == 0) ? 32'hFFFFFFFC : {$urandom} & 32'hFFFFFFFC;
      thread_halt  = ($urandom_range(7) == 0);
      halt_tid     = 3'($urandom_range(7));
      redirect_e   = ($urandom_range(3) == 0);
      redirect_tid = ($urandom_range(1) == 0) ? 3'((m_last + 1) % 8) : 3'($urandom_range(7));
      redirect_pc  = {$urandom} & 32'hFFFFFFFC;
      step_chk("rnd");
    end

    // Asynchronous reset mid-run
    clr_in();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_valid", 32'(valid_f), 0);
    chk("arst_tid", 32'(tid_f), 0);
    chk("arst_pc", pc_f, 0);
    chk("arst_mask", 32'(active_mask), 1);
    chk("arst_idle", 32'(idle), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) step_chk("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
